// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Purpose  : Instruction-fetch stage. Owns the PC, issues one request at a
//            time to instruction memory over a req/ack handshake, presents
//            each fetched word and its PC to the IF/ID register, absorbs
//            stalls with a 1-entry skid buffer and handles redirects,
//            including redirects that hit a request already in flight.
// Ports    : clk_i, rst_i            clock, synchronous active-high reset
//            stall_i, MemStall_i     hazard / data-memory stalls (IF/ID hold)
//            flush_i, target_i       redirect request and new PC
//            imem_req_o, imem_addr_o instruction-memory request and address
//            imem_ack_i, imem_data_i memory response
//            instr_o, PC_o           offer to IF/ID (0/0 = bubble)
//            fetch_cnt_o, drop_cnt_o performance counters (IF_PERF_EN only)
// Config   : define IF_PERF_EN to add the accepted/discarded ack counters.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        MemStall_i,
    input  logic        flush_i,
    input  logic [31:0] target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] instr_o,
    output logic [31:0] PC_o
`ifdef IF_PERF_EN
    ,
    output logic [31:0] fetch_cnt_o,
    output logic [15:0] drop_cnt_o
`endif
);

    localparam logic [1:0] c_ST_FETCH = 2'd0;
    localparam logic [1:0] c_ST_IDLE  = 2'd1;
    localparam logic [1:0] c_ST_DROP  = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_addr;
    logic [31:0] r_offer_instr;
    logic [31:0] r_offer_pc;
    logic        r_skid_vld;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;

    logic        w_consume;
    logic        w_ack;
    logic        w_offer_empty;
    logic [31:0] w_pc_inc;

    // The request is forced low while reset is asserted so that a reset in
    // the middle of a transaction abandons it immediately.
    assign imem_req_o    = ~rst_i & (r_state != c_ST_IDLE);
    assign imem_addr_o   = rst_i ? 32'h0 : r_addr;
    assign instr_o       = r_offer_instr;
    assign PC_o          = r_offer_pc;

    assign w_consume     = ~stall_i & ~MemStall_i;
    assign w_ack         = imem_req_o & imem_ack_i;
    // A fetched all-zero word is treated as a bubble (it is a NOP anyway).
    assign w_offer_empty = (r_offer_instr == 32'h0);
    assign w_pc_inc      = r_pc + PC_INC;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= c_ST_FETCH;
            r_pc          <= RESET_PC;
            r_addr        <= RESET_PC;
            r_offer_instr <= 32'h0;
            r_offer_pc    <= 32'h0;
            r_skid_vld    <= 1'b0;
            r_skid_instr  <= 32'h0;
            r_skid_pc     <= 32'h0;
        end else if (flush_i) begin
            r_offer_instr <= 32'h0;
            r_offer_pc    <= 32'h0;
            r_skid_vld    <= 1'b0;
            r_skid_instr  <= 32'h0;
            r_skid_pc     <= 32'h0;
            r_pc          <= target_i;
            case (r_state)
                c_ST_FETCH: begin
                    if (w_ack) begin
                        // Response arrived with the redirect: drop it and
                        // launch the target fetch straight away.
                        r_addr <= target_i;
                    end else begin
                        // Response still owed for the stale address; keep
                        // the request up until it arrives, then discard it.
                        r_state <= c_ST_DROP;
                    end
                end
                c_ST_IDLE: begin
                    r_state <= c_ST_FETCH;
                    r_addr  <= target_i;
                end
                c_ST_DROP: begin
                    r_state <= c_ST_DROP;
                end
                default: begin
                    r_state <= c_ST_FETCH;
                    r_addr  <= target_i;
                end
            endcase
        end else if (w_ack && (r_state == c_ST_DROP)) begin
            // Stale response discarded; offer and skid are already empty
            // since the redirect, so there is nothing to advance.
            r_state <= c_ST_FETCH;
            r_addr  <= r_pc;
        end else if (w_ack) begin
            r_pc <= w_pc_inc;
            if (w_offer_empty || w_consume) begin
                if (r_skid_vld) begin
                    r_offer_instr <= r_skid_instr;
                    r_offer_pc    <= r_skid_pc;
                    r_skid_instr  <= imem_data_i;
                    r_skid_pc     <= r_addr;
                    r_state       <= c_ST_IDLE;
                end else begin
                    r_offer_instr <= imem_data_i;
                    r_offer_pc    <= r_addr;
                    r_state       <= c_ST_FETCH;
                    r_addr        <= w_pc_inc;
                end
            end else begin
                r_skid_vld   <= 1'b1;
                r_skid_instr <= imem_data_i;
                r_skid_pc    <= r_addr;
                r_state      <= c_ST_IDLE;
            end
        end else if (w_consume) begin
            r_offer_instr <= r_skid_vld ? r_skid_instr : 32'h0;
            r_offer_pc    <= r_skid_vld ? r_skid_pc    : 32'h0;
            r_skid_vld    <= 1'b0;
            if (r_state == c_ST_IDLE) begin
                r_state <= c_ST_FETCH;
                r_addr  <= r_pc;
            end
        end
    end

`ifdef IF_PERF_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_cnt_o <= 32'h0;
            drop_cnt_o  <= 16'h0;
        end else if (w_ack) begin
            if (flush_i || (r_state == c_ST_DROP)) begin
                drop_cnt_o <= drop_cnt_o + 16'd1;
            end else begin
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Purpose  : Self-checking bench for if_fetch_unit: a per-cycle vector table
//            for redirect/stall/reset corner cases, a scoreboarded random
//            stall/ack run, and a PC wrap-around check on a second instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    localparam logic [31:0] c_DBASE = 32'hD000_0000;

    logic        clk;
    logic        rst, stall, mstall, flush, ack;
    logic [31:0] target;
    logic        req;
    logic [31:0] addr, instr, pc, data;

    logic        rst2, ack2;
    logic        req2;
    logic [31:0] addr2, instr2, pc2, data2;
`ifdef IF_PERF_EN
    logic [31:0] fcnt, fcnt2;
    logic [15:0] dcnt, dcnt2;
`endif

    // Instruction memory: word content is derived from its address.
    assign data  = addr  + c_DBASE;
    assign data2 = addr2 + c_DBASE;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .PC_INC(32'd4)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .MemStall_i(mstall),
        .flush_i(flush), .target_i(target), .imem_req_o(req),
        .imem_addr_o(addr), .imem_ack_i(ack), .imem_data_i(data),
        .instr_o(instr), .PC_o(pc)
`ifdef IF_PERF_EN
        , .fetch_cnt_o(fcnt), .drop_cnt_o(dcnt)
`endif
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_INC(32'd4)) dut2 (
        .clk_i(clk), .rst_i(rst2), .stall_i(1'b0), .MemStall_i(1'b0),
        .flush_i(1'b0), .target_i(32'h0), .imem_req_o(req2),
        .imem_addr_o(addr2), .imem_ack_i(ack2), .imem_data_i(data2),
        .instr_o(instr2), .PC_o(pc2)
`ifdef IF_PERF_EN
        , .fetch_cnt_o(fcnt2), .drop_cnt_o(dcnt2)
`endif
    );

    typedef struct {
        logic        rst, stall, mstall, flush, ack;
        logic [31:0] target;
        logic        e_req;
        logic [31:0] e_addr, e_instr, e_pc;
    } vec_t;

    typedef struct {
        logic [31:0] instr, pc;
    } pair_t;

    vec_t  vecs[$];
    pair_t sb[$];
    int    n_checks = 0;
    int    n_err    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic m, input logic f,
                       input logic [31:0] t, input logic a, input logic er,
                       input logic [31:0] ea, input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.rst = r; v.stall = s; v.mstall = m; v.flush = f; v.target = t; v.ack = a;
        v.e_req = er; v.e_addr = ea; v.e_instr = ei; v.e_pc = ep;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] exp_addr;
        pair_t       p;
        rst = 1'b1; stall = 1'b0; mstall = 1'b0; flush = 1'b0; ack = 1'b0; target = 32'h0;
        rst2 = 1'b1; ack2 = 1'b0;

        //   rst s m f target    ack  req addr      instr            pc
        add(1, 0, 0, 0, 32'h0,   0,   0, 32'h0,   32'h0,           32'h0);
        // sequential fetch, one ack per cycle
        add(0, 0, 0, 0, 32'h0,   1,   1, 32'h0,   32'h0,           32'h0);
        add(0, 0, 0, 0, 32'h0,   1,   1, 32'h4,   c_DBASE+32'h0,   32'h0);
        add(0, 0, 0, 0, 32'h0,   0,   1, 32'h8,   c_DBASE+32'h4,   32'h4);
        add(0, 0, 0, 0, 32'h0,   0,   1, 32'h8,   32'h0,           32'h0);
        // stall while acks continue: offer holds, skid fills, request drops
        add(0, 1, 0, 0, 32'h0,   1,   1, 32'h8,   32'h0,           32'h0);
        add(0, 1, 0, 0, 32'h0,   1,   1, 32'hC,   c_DBASE+32'h8,   32'h8);
        add(0, 1, 0, 0, 32'h0,   1,   0, 32'hC,   c_DBASE+32'h8,   32'h8);
        add(0, 1, 0, 0, 32'h0,   0,   0, 32'hC,   c_DBASE+32'h8,   32'h8);
        add(0, 0, 0, 0, 32'h0,   1,   0, 32'hC,   c_DBASE+32'h8,   32'h8);
        add(0, 0, 0, 0, 32'h0,   0,   1, 32'h10,  c_DBASE+32'hC,   32'hC);
        // redirect with a request pending: stale ack discarded
        add(0, 0, 0, 1, 32'h100, 0,   1, 32'h10,  32'h0,           32'h0);
        add(0, 0, 0, 0, 32'h0,   0,   1, 32'h10,  32'h0,           32'h0);
        add(0, 0, 0, 0, 32'h0,   1,   1, 32'h10,  32'h0,           32'h0);
        add(0, 0, 0, 0, 32'h0,   1,   1, 32'h100, 32'h0,           32'h0);
        add(0, 0, 0, 0, 32'h0,   0,   1, 32'h104, c_DBASE+32'h100, 32'h100);
        // redirect and ack on the same edge
        add(0, 0, 0, 1, 32'h200, 1,   1, 32'h104, 32'h0,           32'h0);
        add(0, 0, 0, 0, 32'h0,   0,   1, 32'h200, 32'h0,           32'h0);
        // fill offer+skid, then stall and redirect together
        add(0, 1, 0, 0, 32'h0,   1,   1, 32'h200, 32'h0,           32'h0);
        add(0, 1, 0, 0, 32'h0,   1,   1, 32'h204, c_DBASE+32'h200, 32'h200);
        add(0, 1, 0, 1, 32'h300, 0,   0, 32'h204, c_DBASE+32'h200, 32'h200);
        add(0, 1, 0, 0, 32'h0,   0,   1, 32'h300, 32'h0,           32'h0);
        add(0, 0, 0, 0, 32'h0,   1,   1, 32'h300, 32'h0,           32'h0);
        // memory stall holds the offer
        add(0, 0, 1, 0, 32'h0,   0,   1, 32'h304, c_DBASE+32'h300, 32'h300);
        add(0, 0, 1, 0, 32'h0,   0,   1, 32'h304, c_DBASE+32'h300, 32'h300);
        // reset mid-request
        add(1, 0, 0, 0, 32'h0,   0,   0, 32'h0,   c_DBASE+32'h300, 32'h300);
        add(0, 0, 0, 0, 32'h0,   0,   1, 32'h0,   32'h0,           32'h0);

        @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; stall = vecs[i].stall; mstall = vecs[i].mstall;
            flush = vecs[i].flush; target = vecs[i].target; ack = vecs[i].ack;
            #1;
            chk($sformatf("vec%0d req", i),   {31'h0, req}, {31'h0, vecs[i].e_req});
            chk($sformatf("vec%0d addr", i),  addr,  vecs[i].e_addr);
            chk($sformatf("vec%0d instr", i), instr, vecs[i].e_instr);
            chk($sformatf("vec%0d pc", i),    pc,    vecs[i].e_pc);
        end

        // Scoreboarded random run (no redirects): every accepted ack must
        // appear exactly once, in order, when IF/ID consumes it.
        @(negedge clk);
        rst = 1'b1; stall = 1'b0; mstall = 1'b0; flush = 1'b0; ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_addr = 32'h0;
        for (int c = 0; c < 400; c++) begin
            if (c != 0) @(negedge clk);
            stall  = ($urandom_range(0, 3) == 0);
            mstall = ($urandom_range(0, 4) == 0);
            ack    = $urandom_range(0, 1) == 1;
            #1;
            if (~stall && ~mstall && instr != 32'h0) begin
                if (sb.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL sb_unexpected: got instr %h pc %h, expected nothing", instr, pc);
                end else begin
                    p = sb.pop_front();
                    chk("sb_instr", instr, p.instr);
                    chk("sb_pc", pc, p.pc);
                end
            end
            if (req) begin
                chk("sb_addr", addr, exp_addr);
                if (ack) begin
                    p.instr = exp_addr + c_DBASE;
                    p.pc    = exp_addr;
                    sb.push_back(p);
                    exp_addr = exp_addr + 32'd4;
                    chk("sb_depth", sb.size(), (sb.size() <= 2) ? sb.size() : 2);
                end
            end
        end
        // Drain with acks off; both buffered words must come out.
        for (int c = 0; c < 8 && sb.size() != 0; c++) begin
            @(negedge clk);
            stall = 1'b0; mstall = 1'b0; ack = 1'b0;
            #1;
            if (instr != 32'h0) begin
                p = sb.pop_front();
                chk("drain_instr", instr, p.instr);
                chk("drain_pc", pc, p.pc);
            end
        end
        chk("drain_empty", sb.size(), 0);

        // PC wrap-around on the second instance.
        @(negedge clk);
        rst2 = 1'b0;
        #1;
        chk("wrap_req0", {31'h0, req2}, 32'h1);
        chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
        ack2 = 1'b1;
        @(negedge clk);
        #1;
        chk("wrap_addr1", addr2, 32'h0);
        chk("wrap_instr0", instr2, 32'hCFFF_FFFC);
        chk("wrap_pc0", pc2, 32'hFFFF_FFFC);
        @(negedge clk);
        ack2 = 1'b0;
        #1;
        chk("wrap_instr1", instr2, c_DBASE);
        chk("wrap_pc1", pc2, 32'h0);
`ifdef IF_PERF_EN
        chk("perf_fetch", fcnt2, 32'd2);
        chk("perf_drop", {16'h0, dcnt2}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
